// File: rtl/rob_commit.sv
// rob_commit: reorder buffer with in-order, two-wide commit.
// Rename allocates entries in program order. Execution writeback marks
// entries complete. Up to two entries retire per cycle on c_retire_o and
// c_retire_info_o. An entry whose flush flag is set retires alone and
// raises c_flush_o, and the whole buffer clears in that output cycle.
// Optional feature macro: ROB_WB_BYPASS_EN. When it is defined, the commit
// decision also sees the writebacks arriving in the same cycle.
// c_retire_info_o slot layout, MSB first:
//   {w_valid, arf_id[4:0], w_check, rob_id[AW-1:0], data[31:0]}
module rob_commit #(
  parameter  int DEPTH    = 64,
  parameter  int WB_PORTS = 4,
  localparam int AW       = $clog2(DEPTH),
  localparam int INFO_W   = 39 + AW
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [1:0]                     alloc_valid_i,
  input  logic [1:0][4:0]                alloc_areg_i,
  input  logic [1:0]                     alloc_wreg_i,
  input  logic [1:0]                     alloc_check_i,
  output logic                           alloc_ready_o,
  input  logic [WB_PORTS-1:0]            wb_valid_i,
  input  logic [WB_PORTS-1:0][AW-1:0]    wb_robid_i,
  input  logic [WB_PORTS-1:0][31:0]      wb_data_i,
  input  logic [WB_PORTS-1:0]            wb_flush_i,
  output logic [1:0]                     c_retire_o,
  output logic [1:0][INFO_W-1:0]         c_retire_info_o,
  output logic                           c_flush_o,
  output logic [AW:0]                    rob_cnt_o
);

`ifdef ROB_WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  localparam logic [AW+1:0] CNT_MAX   = (AW+2)'(DEPTH);
  localparam logic [AW:0]   CNT_READY = (AW+1)'(DEPTH - 2);

  // Per-entry state
  logic [DEPTH-1:0] valid_reg, complete_reg, wbflush_reg, wreg_reg, check_reg;
  logic [4:0]       areg_mem [DEPTH];
  logic [31:0]      data_mem [DEPTH];

  // Pointers, count, registered outputs
  logic [AW-1:0]            head_reg, tail_reg;
  logic [AW:0]              count_reg;
  logic [1:0]               retire_reg;
  logic [1:0][INFO_W-1:0]   info_reg;
  logic                     flush_out_reg;

  // Per-entry writeback hits, plus the view that the commit logic sees
  logic [DEPTH-1:0] wb_hit, wb_hit_flag, eff_complete, eff_flag;
  logic [31:0]      wb_hit_data [DEPTH];
  logic [31:0]      eff_data    [DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic        hit;
      logic        hflag;
      logic [31:0] hdata;
      // Find the writeback for this entry. The port loop runs downwards so
      // that the lowest-index port wins when two ports target the same id.
      always_comb begin
        hit   = 1'b0;
        hflag = 1'b0;
        hdata = '0;
        for (int p = WB_PORTS - 1; p >= 0; p--) begin
          if (wb_valid_i[p] && (wb_robid_i[p] == AW'(gi))) begin
            hit   = 1'b1;
            hflag = wb_flush_i[p];
            hdata = wb_data_i[p];
          end
        end
      end
      // Writebacks to free entries and writebacks in the flush output
      // cycle are dropped.
      assign wb_hit[gi]       = hit & valid_reg[gi] & ~flush_out_reg;
      assign wb_hit_flag[gi]  = hflag;
      assign wb_hit_data[gi]  = hdata;
      assign eff_complete[gi] = complete_reg[gi] | (BYPASS & wb_hit[gi]);
      assign eff_flag[gi]     = (BYPASS && wb_hit[gi]) ? hflag : wbflush_reg[gi];
      assign eff_data[gi]     = (BYPASS && wb_hit[gi]) ? hdata : data_mem[gi];
    end
  endgenerate

  // Commit decision and allocation bookkeeping
  logic [AW-1:0] head1, tail1;
  logic          ret0, ret1, flush_now;
  logic [1:0]    alloc_n;
  logic [AW+1:0] cnt_sum;
  logic          alloc_illegal, alloc_ok;
  logic [AW:0]   count_next;

  // Decide what retires this cycle and whether the allocation is accepted.
  always_comb begin
    head1     = head_reg + AW'(1);
    tail1     = tail_reg + AW'(1);
    ret0      = valid_reg[head_reg] & eff_complete[head_reg];
    ret1      = ret0 & valid_reg[head1] & eff_complete[head1] &
                ~eff_flag[head_reg] & ~eff_flag[head1];
    flush_now = ret0 & eff_flag[head_reg];
    alloc_n       = {1'b0, alloc_valid_i[0]} + {1'b0, alloc_valid_i[1]};
    cnt_sum       = {1'b0, count_reg} + (AW+2)'(alloc_n);
    alloc_illegal = (alloc_valid_i == 2'b10) || (cnt_sum > CNT_MAX);
    alloc_ok      = (alloc_n != 2'd0) & ~alloc_illegal & ~flush_out_reg & ~flush_now;
    count_next    = count_reg + (AW+1)'(alloc_ok ? alloc_n : 2'd0)
                    - (AW+1)'(ret0) - (AW+1)'(ret1);
  end

  // Control state: pointers, entry flags and the registered commit outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_reg      <= '0;
      tail_reg      <= '0;
      count_reg     <= '0;
      valid_reg     <= '0;
      complete_reg  <= '0;
      wbflush_reg   <= '0;
      wreg_reg      <= '0;
      check_reg     <= '0;
      retire_reg    <= '0;
      info_reg      <= '0;
      flush_out_reg <= 1'b0;
    end else begin
      retire_reg    <= {ret1, ret0};
      flush_out_reg <= flush_now;
      info_reg[0]   <= ret0 ? {wreg_reg[head_reg], areg_mem[head_reg], check_reg[head_reg],
                               head_reg, eff_data[head_reg]} : '0;
      info_reg[1]   <= ret1 ? {wreg_reg[head1], areg_mem[head1], check_reg[head1],
                               head1, eff_data[head1]} : '0;
      if (flush_now) begin
        head_reg     <= '0;
        tail_reg     <= '0;
        count_reg    <= '0;
        valid_reg    <= '0;
        complete_reg <= '0;
        wbflush_reg  <= '0;
      end else begin
        head_reg  <= head_reg + AW'(ret0) + AW'(ret1);
        count_reg <= count_next;
        for (int e = 0; e < DEPTH; e++) begin
          if (wb_hit[e]) begin
            complete_reg[e] <= 1'b1;
            wbflush_reg[e]  <= wb_hit_flag[e];
          end
        end
        if (ret0) valid_reg[head_reg] <= 1'b0;
        if (ret1) valid_reg[head1]    <= 1'b0;
        // Allocated entries are always free, so they never collide with
        // the retiring or writeback entries above.
        if (alloc_ok) begin
          tail_reg               <= tail_reg + AW'(alloc_n);
          valid_reg[tail_reg]    <= 1'b1;
          complete_reg[tail_reg] <= 1'b0;
          wbflush_reg[tail_reg]  <= 1'b0;
          wreg_reg[tail_reg]     <= alloc_wreg_i[0];
          check_reg[tail_reg]    <= alloc_check_i[0];
          if (alloc_valid_i[1]) begin
            valid_reg[tail1]    <= 1'b1;
            complete_reg[tail1] <= 1'b0;
            wbflush_reg[tail1]  <= 1'b0;
            wreg_reg[tail1]     <= alloc_wreg_i[1];
            check_reg[tail1]    <= alloc_check_i[1];
          end
        end
      end
    end
  end

  // Payload storage (result data and destination register), no reset needed.
  always_ff @(posedge clk) begin
    for (int e = 0; e < DEPTH; e++) begin
      if (wb_hit[e] && !flush_now) data_mem[e] <= wb_hit_data[e];
    end
    if (alloc_ok) begin
      areg_mem[tail_reg] <= alloc_areg_i[0];
      if (alloc_valid_i[1]) areg_mem[tail1] <= alloc_areg_i[1];
    end
  end

  // Illegal allocations are dropped in hardware; flag them in simulation.
  a_alloc_legal : assert property (@(posedge clk) disable iff (!rst_n) !alloc_illegal)
    else $warning("rob_commit: illegal allocation dropped (valid=%b count=%0d)",
                  alloc_valid_i, count_reg);

  assign alloc_ready_o   = (count_reg <= CNT_READY);
  assign c_retire_o      = retire_reg;
  assign c_retire_info_o = info_reg;
  assign c_flush_o       = flush_out_reg;
  assign rob_cnt_o       = count_reg;

endmodule

// File: tb/tb_rob_commit.sv
// tb_rob_commit: directed bench for rob_commit with hand-computed expectations.
// It honours ROB_WB_BYPASS_EN, which sets the expected writeback-to-retire
// latency.
module tb_rob_commit;

`ifdef ROB_WB_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif
  localparam int INFO_W = 45;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [1:0]             alloc_valid;
  logic [1:0][4:0]        alloc_areg;
  logic [1:0]             alloc_wreg, alloc_check;
  logic                   alloc_ready;
  logic [3:0]             wb_valid;
  logic [3:0][5:0]        wb_robid;
  logic [3:0][31:0]       wb_data;
  logic [3:0]             wb_flush;
  logic [1:0]             c_retire;
  logic [1:0][INFO_W-1:0] c_info;
  logic                   c_flush;
  logic [6:0]             rob_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  int lat;

  rob_commit #(.DEPTH(64), .WB_PORTS(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_valid_i(alloc_valid), .alloc_areg_i(alloc_areg),
    .alloc_wreg_i(alloc_wreg), .alloc_check_i(alloc_check),
    .alloc_ready_o(alloc_ready),
    .wb_valid_i(wb_valid), .wb_robid_i(wb_robid),
    .wb_data_i(wb_data), .wb_flush_i(wb_flush),
    .c_retire_o(c_retire), .c_retire_info_o(c_info),
    .c_flush_o(c_flush), .rob_cnt_o(rob_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [INFO_W-1:0] mk_info(input bit w, input int areg, input bit c,
                                                input int id, input logic [31:0] d);
    return {w, 5'(areg), c, 6'(id), d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alloc_valid = '0; alloc_areg = '0; alloc_wreg = '0; alloc_check = '0;
    wb_valid = '0; wb_robid = '0; wb_data = '0; wb_flush = '0;
  endtask

  task automatic do_alloc(input logic [1:0] v, input int a0, input int a1,
                          input logic [1:0] w, input logic [1:0] c);
    alloc_valid = v; alloc_areg[0] = 5'(a0); alloc_areg[1] = 5'(a1);
    alloc_wreg = w; alloc_check = c;
  endtask

  task automatic set_wb(input int p, input int id, input logic [31:0] d, input bit f);
    wb_valid[p] = 1'b1; wb_robid[p] = 6'(id); wb_data[p] = d; wb_flush[p] = f;
  endtask

  // Clock the current inputs once, then idle until a retire shows up.
  task automatic wait_retire(output int l);
    l = -1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      idle();
      if (c_retire != 2'b00) begin
        l = k;
        $display("retire %b ids %0d,%0d flush %b after %0d cycle(s)",
                 c_retire, c_info[0][37:32], c_info[1][37:32], c_flush, k);
        break;
      end
    end
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    idle();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    idle();
    tick();
    tick();
    // Reset state
    chk("rst_retire", 64'(c_retire), 64'h0);
    chk("rst_flush",  64'(c_flush), 64'h0);
    chk("rst_cnt",    64'(rob_cnt), 64'h0);
    chk("rst_ready",  64'(alloc_ready), 64'h1);
    chk("rst_info",   64'(c_info[0] | c_info[1]), 64'h0);
    rst_n = 1'b1;

    // Pair retire; ports 2 and 3 both hit id1 and port 2 must win (no flush)
    do_alloc(2'b11, 3, 4, 2'b11, 2'b01);
    tick();
    chk("t2_cnt", 64'(rob_cnt), 64'd2);
    idle();
    set_wb(2, 1, 32'hAAAA_0001, 1'b0);
    set_wb(3, 1, 32'hBBBB_0002, 1'b1);
    tick();
    idle();
    chk("t2_early", 64'(c_retire), 64'h0);
    set_wb(0, 0, 32'h1234_5678, 1'b0);
    wait_retire(lat);
    chk("t2_lat",    64'(lat), 64'(LAT));
    chk("t2_retire", 64'(c_retire), 64'b11);
    chk("t2_info0",  64'(c_info[0]), 64'(mk_info(1, 3, 1, 0, 32'h1234_5678)));
    chk("t2_info1",  64'(c_info[1]), 64'(mk_info(1, 4, 0, 1, 32'hAAAA_0001)));
    chk("t2_flush",  64'(c_flush), 64'h0);
    chk("t2_cnt0",   64'(rob_cnt), 64'd0);
    tick();
    chk("t2_pulse",  64'(c_retire), 64'h0);

    // Asynchronous reset in the middle of a retire output cycle
    do_alloc(2'b11, 1, 2, 2'b11, 2'b00); tick();
    do_alloc(2'b11, 1, 2, 2'b11, 2'b00); tick();
    do_alloc(2'b01, 1, 0, 2'b01, 2'b00); tick();
    idle();
    chk("t1_cnt5", 64'(rob_cnt), 64'd5);
    set_wb(0, 2, 32'h0000_0055, 1'b0);
    wait_retire(lat);
    chk("t1_retire", 64'(c_retire), 64'b01);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_a_retire", 64'(c_retire), 64'h0);
    chk("t1_a_info",   64'(c_info[0]), 64'h0);
    chk("t1_a_flush",  64'(c_flush), 64'h0);
    chk("t1_a_cnt",    64'(rob_cnt), 64'h0);
    chk("t1_a_ready",  64'(alloc_ready), 64'h1);
    tick();
    rst_n = 1'b1;

    // Flush entry retires alone, clears the buffer, inputs ignored that cycle
    do_alloc(2'b11, 1, 2, 2'b11, 2'b00); tick();
    do_alloc(2'b01, 5, 0, 2'b01, 2'b00); tick();
    idle();
    set_wb(0, 0, 32'hD000_0000, 1'b0);
    set_wb(1, 1, 32'hD000_0001, 1'b1);
    set_wb(2, 2, 32'hD000_0002, 1'b0);
    wait_retire(lat);
    chk("t3_lat",     64'(lat), 64'(LAT));
    chk("t3_retireA", 64'(c_retire), 64'b01);
    chk("t3_infoA",   64'(c_info[0]), 64'(mk_info(1, 1, 0, 0, 32'hD000_0000)));
    chk("t3_flushA",  64'(c_flush), 64'h0);
    chk("t3_cntA",    64'(rob_cnt), 64'd2);
    tick();
    chk("t3_retireB", 64'(c_retire), 64'b01);
    chk("t3_infoB",   64'(c_info[0]), 64'(mk_info(1, 2, 0, 1, 32'hD000_0001)));
    chk("t3_flushB",  64'(c_flush), 64'h1);
    chk("t3_cntB",    64'(rob_cnt), 64'd0);
    do_alloc(2'b11, 7, 8, 2'b11, 2'b00);
    set_wb(0, 0, 32'hEEEE_EEEE, 1'b0);
    tick();
    idle();
    chk("t3_ign_cnt",  64'(rob_cnt), 64'd0);
    chk("t3_ign_ret",  64'(c_retire), 64'h0);
    chk("t3_ign_fl",   64'(c_flush), 64'h0);
    do_alloc(2'b11, 7, 8, 2'b11, 2'b00);
    tick();
    idle();
    chk("t3_resume", 64'(rob_cnt), 64'd2);
    reset_dut();

    // Occupancy thresholds for alloc_ready
    for (int i = 0; i < 31; i++) begin
      do_alloc(2'b11, i, i + 1, 2'b11, 2'b00);
      tick();
    end
    idle();
    chk("t4_cnt62",   64'(rob_cnt), 64'd62);
    chk("t4_rdy62",   64'(alloc_ready), 64'h1);
    do_alloc(2'b01, 9, 0, 2'b01, 2'b00);
    tick();
    idle();
    chk("t4_cnt63",   64'(rob_cnt), 64'd63);
    chk("t4_rdy63",   64'(alloc_ready), 64'h0);
    set_wb(0, 0, 32'h0000_0F00, 1'b0);
    wait_retire(lat);
    chk("t4_ret",     64'(c_retire), 64'b01);
    chk("t4_cntback", 64'(rob_cnt), 64'd62);
    chk("t4_rdyback", 64'(alloc_ready), 64'h1);
    do_alloc(2'b11, 1, 2, 2'b11, 2'b00);
    tick();
    idle();
    chk("t4_full",    64'(rob_cnt), 64'd64);
    chk("t4_rdyfull", 64'(alloc_ready), 64'h0);
    reset_dut();

    // 70 instructions in pairs: ids wrap 63 -> 0 in order
    for (int i = 0; i < 35; i++) begin
      int a, b;
      a = (2 * i) % 64;
      b = (2 * i + 1) % 64;
      do_alloc(2'b11, i % 32, (i + 1) % 32, 2'b11, 2'b10);
      tick();
      idle();
      set_wb(0, a, 32'hC000_0000 + 32'(2 * i), 1'b0);
      set_wb(1, b, 32'hC000_0000 + 32'(2 * i + 1), 1'b0);
      wait_retire(lat);
      chk("t5_retire", 64'(c_retire), 64'b11);
      chk("t5_info0",  64'(c_info[0]), 64'(mk_info(1, i % 32, 0, a, 32'hC000_0000 + 32'(2 * i))));
      chk("t5_info1",  64'(c_info[1]), 64'(mk_info(1, (i + 1) % 32, 1, b, 32'hC000_0000 + 32'(2 * i + 1))));
    end
    chk("t5_cnt", 64'(rob_cnt), 64'd0);

    // Illegal alloc pattern and writeback to a freed id (head = tail = 6)
    do_alloc(2'b10, 3, 4, 2'b11, 2'b11);
    tick();
    idle();
    chk("t6_drop_cnt", 64'(rob_cnt), 64'd0);
    chk("t6_drop_rdy", 64'(alloc_ready), 64'h1);
    do_alloc(2'b01, 9, 0, 2'b01, 2'b01);
    tick();
    idle();
    chk("t6_cnt1", 64'(rob_cnt), 64'd1);
    set_wb(0, 7, 32'h0000_DEAD, 1'b1);
    tick();
    idle();
    chk("t6_ign_cnt", 64'(rob_cnt), 64'd1);
    chk("t6_ign_ret", 64'(c_retire), 64'h0);
    do_alloc(2'b01, 10, 0, 2'b01, 2'b00);
    tick();
    idle();
    set_wb(0, 6, 32'h0000_0066, 1'b0);
    wait_retire(lat);
    chk("t6_retire", 64'(c_retire), 64'b01);
    chk("t6_info",   64'(c_info[0]), 64'(mk_info(1, 9, 1, 6, 32'h0000_0066)));
    chk("t6_flush",  64'(c_flush), 64'h0);
    tick();
    chk("t6_after",  64'(c_retire), 64'h0);
    chk("t6_left",   64'(rob_cnt), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
